instr_encoder: RTL

//  Packs RV32I instruction fields plus a 32-bit immediate into a 32-bit instruction word.
//  It is the inverse of immediate_generator: opcode-selected I/S/B/J/U/shift packing.

---
 rtl/instr_encoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs RV32I instruction fields plus a 32-bit (pre-shift, signed) immediate
//   into a 32-bit instruction word. This is the inverse of immediate_generator.
//   The encoder is combinational at the input. Each {word, err} pair is
//   buffered in a small FIFO that uses valid/ready handshakes on both sides.
//
//   Optional feature macro: ENC_RANGE_CHECK_EN
//     When defined, err is also raised when the immediate cannot round-trip
//     through the selected format. The word is still packed from the
//     truncated bits. Unknown-opcode detection (NOP + err) is always active.
//
// Parameters
//   DEPTH  output FIFO entries (power of two, >= 2)
//   CNT_W  width of the accept / error counters
//
// Ports
//   i_clk, i_rst_n             clock (rising edge), async active-low reset
//   i_in_valid / o_in_ready    input handshake (ready = FIFO not full)
//   i_opcode, i_rd, i_funct3,
//   i_rs1, i_rs2, i_funct7,
//   i_imm                      instruction fields to pack
//   o_out_valid / i_out_ready  output handshake (FIFO head)
//   o_instr, o_err             encoded word and error flag at the FIFO head
//   o_enc_count, o_err_count   accepted words / accepted words with err (wrap)
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [6:0]       i_funct7,
  input  logic [31:0]      i_imm,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_enc_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BRAN = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIP = 7'b0010111;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_err;
  logic        range_err;

  always_comb begin
    enc_word  = 32'h0000_0013;
    enc_err   = 1'b0;
    range_err = 1'b0;
    case (i_opcode)
      OP_IMM: begin
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
          // Shifts: the shamt sits in the low five immediate bits, and funct7
          // supplies the upper bits (this distinguishes srli from srai).
          enc_word  = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
          range_err = |i_imm[31:5];
        end else begin
          enc_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          range_err = !((&i_imm[31:11]) || !(|i_imm[31:11]));
        end
      end
      OP_LOAD, OP_JALR: begin
        enc_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        range_err = !((&i_imm[31:11]) || !(|i_imm[31:11]));
      end
      OP_STOR: begin
        enc_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        range_err = !((&i_imm[31:11]) || !(|i_imm[31:11]));
      end
      OP_BRAN: begin
        enc_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], i_opcode};
        range_err = i_imm[0] || !((&i_imm[31:12]) || !(|i_imm[31:12]));
      end
      OP_JAL: begin
        enc_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        range_err = i_imm[0] || !((&i_imm[31:20]) || !(|i_imm[31:20]));
      end
      OP_LUI, OP_AUIP: begin
        enc_word  = {i_imm[31:12], i_rd, i_opcode};
        range_err = |i_imm[11:0];
      end
      OP_REG: begin
        enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      default: begin
        // Unknown opcode: substitute a NOP so downstream never sees garbage.
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    enc_err = enc_err | range_err;
`endif
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (wrap-bit pointers)
  // ---------------------------------------------------------------------------
  logic [32:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          ready_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [32:0]   head;
  logic [CNT_W-1:0] enc_count_reg;
  logic [CNT_W-1:0] err_count_reg;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // ready_reg holds o_in_ready low for as long as reset is asserted.
  assign o_in_ready  = ready_reg && !full;
  assign o_out_valid = !empty;
  assign push        = i_in_valid && o_in_ready;
  assign pop         = o_out_valid && i_out_ready;

  assign head    = mem[rd_ptr_reg[AW-1:0]];
  assign o_instr = empty ? 32'h0 : head[31:0];
  assign o_err   = empty ? 1'b0  : head[32];

  assign o_enc_count = enc_count_reg;
  assign o_err_count = err_count_reg;

  // Storage has no reset. Stale contents are hidden by the empty gating above.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {enc_err, enc_word};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ready_reg     <= 1'b0;
      enc_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      ready_reg <= 1'b1;
      if (push) begin
        wr_ptr_reg    <= wr_ptr_reg + 1'b1;
        enc_count_reg <= enc_count_reg + 1'b1;
        if (enc_err) begin
          err_count_reg <= err_count_reg + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule
